// File: rtl/commit_stage_pkg.sv
`default_nettype none
// ============================================================================
// commit_stage_pkg : record layout, sizes and commit FSM encoding
// Rev 1.0
// ============================================================================
package commit_stage_pkg;

    localparam int CS_DW   = 77;
    localparam int CS_PRN  = 64;
    localparam int CS_PRB  = 6;
    localparam int ARCH_W  = 5;

    // Record layout, LSB first: is_su, is_branch, rd0_phy, rd0_arch, pc
    localparam int REC_SU_BIT   = 0;
    localparam int REC_BR_BIT   = 1;
    localparam int REC_PHY_LSB  = 2;
    localparam int REC_ARCH_LSB = REC_PHY_LSB + CS_PRB;
    localparam int REC_PC_LSB   = REC_ARCH_LSB + ARCH_W;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } commit_state_e;

endpackage
`default_nettype wire

// File: rtl/commit_flush_fsm.sv
`default_nettype none
// ============================================================================
// commit_flush_fsm : RUN/FLUSH/RECOVER sequencing and the one-shot abort
// Rev 1.0
// ============================================================================
module commit_flush_fsm
    import commit_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mispredict_pop,
    input  logic [63:0] pop_pc,
    input  logic        flush_ack,
    output logic        run,
    output logic        commit_abort,
    output logic [63:0] abort_pc
);

    commit_state_e state;

    assign run = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            commit_abort <= 1'b0;
            abort_pc     <= 64'd0;
        end else begin
            commit_abort <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (mispredict_pop) begin
                        state        <= ST_FLUSH;
                        commit_abort <= 1'b1;
                        abort_pc     <= pop_pc;
                    end
                end
                // flush_ack only matters once the flush has been broadcast
                ST_FLUSH:   state <= ST_RECOVER;
                ST_RECOVER: if (flush_ack) state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/commit_stage.sv
`default_nettype none
// ============================================================================
// commit_stage : in-order retirement of the reorder FIFO head
// Rev 1.0
// ============================================================================
module commit_stage
    import commit_stage_pkg::*;
#(
    parameter  int DW  = CS_DW,
    parameter  int PRN = CS_PRN,
    localparam int PRB = $clog2(PRN)
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              iOrder_vaild,
    output logic              commit_ready,
    input  logic [DW-1:0]     iOrder_info_pop,
    input  logic [PRN-1:0]    wbLog_qout,
    input  logic              bru_res_vaild,
    input  logic              bru_mispredict,
    input  logic              su_ready,
    output logic              su_commit,
    output logic              rod_commit_vaild,
    output logic [ARCH_W-1:0] commit_rd0_arch,
    output logic [PRB-1:0]    commit_rd0_phy,
    output logic              commit_abort,
    output logic [63:0]       abort_pc,
    input  logic              flush_ack,
    output logic [63:0]       instret
);

    logic [63:0]       head_pc;
    logic [ARCH_W-1:0] head_arch;
    logic [PRB-1:0]    head_phy;
    logic              head_br;
    logic              head_su;
    logic              fsm_run;
    logic              rd_ok;
    logic              su_ok;
    logic              br_ok;
    logic              mispredict_pop;

    assign head_pc   = iOrder_info_pop[REC_PC_LSB +: 64];
    assign head_arch = iOrder_info_pop[REC_ARCH_LSB +: ARCH_W];
    assign head_phy  = iOrder_info_pop[REC_PHY_LSB +: PRB];
    assign head_br   = iOrder_info_pop[REC_BR_BIT];
    assign head_su   = iOrder_info_pop[REC_SU_BIT];

    // x0 has no physical mapping to wait on
    assign rd_ok = (head_arch == '0) || wbLog_qout[head_phy];
    assign su_ok = !head_su || su_ready;
    assign br_ok = !head_br || bru_res_vaild;

    // RSTn term keeps the pop strobe quiet while reset is held
    assign commit_ready   = RSTn && iOrder_vaild && fsm_run && rd_ok && su_ok && br_ok;
    assign su_commit      = commit_ready && head_su;
    assign mispredict_pop = commit_ready && head_br && bru_mispredict;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rod_commit_vaild <= 1'b0;
            commit_rd0_arch  <= '0;
            commit_rd0_phy   <= '0;
            instret          <= 64'd0;
        end else begin
            rod_commit_vaild <= commit_ready && (head_arch != '0);
            if (commit_ready) begin
                commit_rd0_arch <= head_arch;
                commit_rd0_phy  <= head_phy;
                instret         <= instret + 64'd1;
            end
        end
    end

    commit_flush_fsm u_fsm (
        .clk            (CLK),
        .rst_n          (RSTn),
        .mispredict_pop (mispredict_pop),
        .pop_pc         (head_pc),
        .flush_ack      (flush_ack),
        .run            (fsm_run),
        .commit_abort   (commit_abort),
        .abort_pc       (abort_pc)
    );

endmodule
`default_nettype wire

// File: tb/tb_commit_stage.sv
`default_nettype none
// ============================================================================
// tb_commit_stage : directed stimulus with queue-based scoreboard
// Rev 1.0
// ============================================================================
module tb_commit_stage;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        iOrder_vaild;
    logic        commit_ready;
    logic [76:0] iOrder_info_pop;
    logic [63:0] wbLog_qout;
    logic        bru_res_vaild;
    logic        bru_mispredict;
    logic        su_ready;
    logic        su_commit;
    logic        rod_commit_vaild;
    logic [4:0]  commit_rd0_arch;
    logic [5:0]  commit_rd0_phy;
    logic        commit_abort;
    logic [63:0] abort_pc;
    logic        flush_ack;
    logic [63:0] instret;

    always #5 CLK = ~CLK;

    commit_stage dut (
        .CLK              (CLK),
        .RSTn             (RSTn),
        .iOrder_vaild     (iOrder_vaild),
        .commit_ready     (commit_ready),
        .iOrder_info_pop  (iOrder_info_pop),
        .wbLog_qout       (wbLog_qout),
        .bru_res_vaild    (bru_res_vaild),
        .bru_mispredict   (bru_mispredict),
        .su_ready         (su_ready),
        .su_commit        (su_commit),
        .rod_commit_vaild (rod_commit_vaild),
        .commit_rd0_arch  (commit_rd0_arch),
        .commit_rd0_phy   (commit_rd0_phy),
        .commit_abort     (commit_abort),
        .abort_pc         (abort_pc),
        .flush_ack        (flush_ack),
        .instret          (instret)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int cyc; logic su; } pop_t;
    typedef struct { int cyc; logic [4:0] arch; logic [5:0] phy; } rod_t;
    typedef struct { int cyc; logic [63:0] pc; } abt_t;
    typedef struct { int cyc; logic [63:0] val; } inst_t;

    pop_t  pop_q[$];
    rod_t  rod_q[$];
    abt_t  abt_q[$];
    inst_t inst_q[$];

    logic [63:0] exp_inst = 64'd0;

    function automatic logic [76:0] mk(input logic [63:0] pc, input logic [4:0] a,
                                       input logic [5:0] p, input logic br, input logic su);
        return {pc, a, p, br, su};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic exp_pop(input logic su);
        pop_q.push_back('{cyc, su});
        exp_inst = exp_inst + 64'd1;
        inst_q.push_back('{cyc + 1, exp_inst});
    endtask

    // Monitor: samples on the falling edge, consumes scoreboard entries
    initial begin : mon
        pop_t  pe;
        rod_t  re;
        abt_t  ae;
        inst_t ie;
        forever begin
            @(negedge CLK);
            if (commit_ready) begin
                checks++;
                if (pop_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: commit_ready=1 su_commit=%b at cyc %0d, expected no pop", su_commit, cyc);
                end else begin
                    pe = pop_q.pop_front();
                    if (pe.cyc != cyc || pe.su !== su_commit) begin
                        errors++;
                        $display("FAIL pop: got cyc=%0d su_commit=%b, expected cyc=%0d su_commit=%b", cyc, su_commit, pe.cyc, pe.su);
                    end
                end
            end else if (su_commit) begin
                checks++;
                errors++;
                $display("FAIL su_commit_alone: su_commit=1 with commit_ready=0 at cyc %0d, expected 0", cyc);
            end
            if (rod_commit_vaild) begin
                checks++;
                if (rod_q.size() == 0) begin
                    errors++;
                    $display("FAIL rod_unexpected: rod_commit_vaild=1 arch=%0d at cyc %0d, expected 0", commit_rd0_arch, cyc);
                end else begin
                    re = rod_q.pop_front();
                    if (re.cyc != cyc || re.arch !== commit_rd0_arch || re.phy !== commit_rd0_phy) begin
                        errors++;
                        $display("FAIL rod: got cyc=%0d arch=%0d phy=%0d, expected cyc=%0d arch=%0d phy=%0d",
                                 cyc, commit_rd0_arch, commit_rd0_phy, re.cyc, re.arch, re.phy);
                    end
                end
            end
            if (commit_abort) begin
                checks++;
                if (abt_q.size() == 0) begin
                    errors++;
                    $display("FAIL abort_unexpected: commit_abort=1 at cyc %0d, expected 0", cyc);
                end else begin
                    ae = abt_q.pop_front();
                    if (ae.cyc != cyc || ae.pc !== abort_pc) begin
                        errors++;
                        $display("FAIL abort: got cyc=%0d pc=%h, expected cyc=%0d pc=%h", cyc, abort_pc, ae.cyc, ae.pc);
                    end
                end
            end
            while (inst_q.size() > 0 && inst_q[0].cyc <= cyc) begin
                ie = inst_q.pop_front();
                chk("instret", instret, ie.val);
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        RSTn            = 1'b0;
        iOrder_vaild    = 1'b1;
        iOrder_info_pop = mk(64'h0, 5'd0, 6'd0, 1'b0, 1'b1);
        wbLog_qout      = '0;
        bru_res_vaild   = 1'b0;
        bru_mispredict  = 1'b0;
        su_ready        = 1'b1;
        flush_ack       = 1'b0;

        // Reset state with a would-be-ready store head
        #12;
        chk("reset_commit_ready", {63'd0, commit_ready}, 64'd0);
        chk("reset_su_commit", {63'd0, su_commit}, 64'd0);
        chk("reset_rod", {63'd0, rod_commit_vaild}, 64'd0);
        chk("reset_abort", {63'd0, commit_abort}, 64'd0);
        chk("reset_abort_pc", abort_pc, 64'd0);
        chk("reset_instret", instret, 64'd0);
        tick();
        RSTn = 1'b1; iOrder_vaild = 1'b0; su_ready = 1'b0;
        tick();

        // Writeback-pending head: only the fifth cycle pops
        iOrder_vaild = 1'b1;
        iOrder_info_pop = mk(64'h40, 5'd3, 6'd9, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wbLog_qout[9] = (i == 4);
            if (i == 4) begin
                exp_pop(1'b0);
                rod_q.push_back('{cyc + 1, 5'd3, 6'd9});
            end
            tick();
        end
        iOrder_vaild = 1'b0; wbLog_qout = '0;
        tick();

        // Store head waits two cycles for su_ready
        iOrder_vaild = 1'b1;
        iOrder_info_pop = mk(64'h100, 5'd0, 6'd0, 1'b0, 1'b1);
        tick();
        tick();
        su_ready = 1'b1;
        exp_pop(1'b1);
        tick();
        iOrder_vaild = 1'b0; su_ready = 1'b0;
        tick();

        // Mispredicted branch, flush, recover on flush_ack
        iOrder_vaild = 1'b1;
        iOrder_info_pop = mk(64'h8000_0010, 5'd0, 6'd0, 1'b1, 1'b0);
        bru_res_vaild = 1'b1; bru_mispredict = 1'b1;
        exp_pop(1'b0);
        abt_q.push_back('{cyc + 1, 64'h8000_0010});
        tick();
        iOrder_info_pop = mk(64'h8000_0014, 5'd0, 6'd0, 1'b0, 1'b0);
        bru_res_vaild = 1'b0; bru_mispredict = 1'b0;
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        tick();
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        exp_pop(1'b0);
        tick();
        iOrder_vaild = 1'b0;
        tick();

        // Store+branch head held by pending writeback despite su/bru ready
        iOrder_vaild = 1'b1;
        iOrder_info_pop = mk(64'h200, 5'd7, 6'd20, 1'b1, 1'b1);
        su_ready = 1'b1; bru_res_vaild = 1'b1; bru_mispredict = 1'b0;
        tick();
        tick();
        wbLog_qout[20] = 1'b1;
        exp_pop(1'b1);
        rod_q.push_back('{cyc + 1, 5'd7, 6'd20});
        tick();
        iOrder_vaild = 1'b0; wbLog_qout = '0; su_ready = 1'b0; bru_res_vaild = 1'b0;
        tick();

        // Reset asserted while in RECOVER
        iOrder_vaild = 1'b1;
        iOrder_info_pop = mk(64'h300, 5'd0, 6'd0, 1'b1, 1'b0);
        bru_res_vaild = 1'b1; bru_mispredict = 1'b1;
        exp_pop(1'b0);
        abt_q.push_back('{cyc + 1, 64'h300});
        tick();
        iOrder_info_pop = mk(64'h304, 5'd0, 6'd0, 1'b0, 1'b0);
        bru_res_vaild = 1'b0; bru_mispredict = 1'b0;
        tick();
        RSTn = 1'b0;
        inst_q.delete();
        exp_inst = 64'd0;
        tick();
        chk("rst_recover_abort", {63'd0, commit_abort}, 64'd0);
        chk("rst_recover_abort_pc", abort_pc, 64'd0);
        chk("rst_recover_instret", instret, 64'd0);
        RSTn = 1'b1;
        exp_pop(1'b0);
        tick();
        iOrder_vaild = 1'b0;
        tick();

        // Eight back-to-back ready heads
        wbLog_qout = '1;
        for (int i = 0; i < 8; i++) begin
            iOrder_vaild = 1'b1;
            iOrder_info_pop = mk(64'h1000 + 64'(4 * i), 5'(i + 1), 6'(i + 10), 1'b0, 1'b0);
            exp_pop(1'b0);
            rod_q.push_back('{cyc + 1, 5'(i + 1), 6'(i + 10)});
            tick();
        end
        iOrder_vaild = 1'b0; wbLog_qout = '0;
        inst_q.push_back('{cyc, 64'd9});
        tick();

        // instret wrap
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        iOrder_vaild = 1'b1;
        iOrder_info_pop = mk(64'h2000, 5'd0, 6'd0, 1'b0, 1'b0);
        inst_q.push_back('{cyc, 64'hFFFF_FFFF_FFFF_FFFF});
        exp_inst = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_pop(1'b0);
        tick();
        iOrder_vaild = 1'b0;
        tick();
        tick();
        tick();

        chk("pop_q_drained", 64'(pop_q.size()), 64'd0);
        chk("rod_q_drained", 64'(rod_q.size()), 64'd0);
        chk("abt_q_drained", 64'(abt_q.size()), 64'd0);
        chk("inst_q_drained", 64'(inst_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
